// File: rtl/led_sampler.sv
// led_sampler: windowed snapshots of the blinky LED lines over valid/ready.
// Define LED_SAMPLER_TOGGLE_CNT_EN to build the per-LED toggle counters.
module led_sampler #(
  parameter int N_LEDS        = 5,
  parameter int SAMPLE_PERIOD = 900000,
  parameter int TCNT_W        = 8
) (
  input  logic                     clki,
  input  logic                     rst,
  input  logic [N_LEDS-1:0]        led_in,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [N_LEDS-1:0]        snap_leds,
  output logic [N_LEDS*TCNT_W-1:0] snap_toggles,
  output logic [15:0]              snap_seq,
  output logic                     overrun
);

  localparam logic [23:0] WLAST = 24'(SAMPLE_PERIOD - 1);

  logic [N_LEDS-1:0] led_m;
  logic [N_LEDS-1:0] led_s;
  logic [23:0]       wcnt;
  logic [15:0]       seq;
  logic              win_end;
  logic              load;

  assign win_end = (wcnt == WLAST);
  // A held snapshot being accepted this cycle frees the slot for the new one.
  assign load    = win_end && (!snap_valid || snap_ready);

  always_ff @(posedge clki) begin
    if (rst) begin
      led_m <= '0;
      led_s <= '0;
      wcnt  <= '0;
    end else begin
      led_m <= led_in;
      led_s <= led_m;
      wcnt  <= win_end ? 24'd0 : wcnt + 24'd1;
    end
  end

`ifdef LED_SAMPLER_TOGGLE_CNT_EN
  logic [N_LEDS-1:0]        led_q;
  logic [N_LEDS-1:0]        tgl;
  logic [N_LEDS*TCNT_W-1:0] tcnt;
  logic [N_LEDS*TCNT_W-1:0] tcnt_inc;

  assign tgl = led_s ^ led_q;

  always_comb begin
    tcnt_inc = tcnt;
    for (int i = 0; i < N_LEDS; i++) begin
      if (tgl[i] && (tcnt[i*TCNT_W +: TCNT_W] != '1))
        tcnt_inc[i*TCNT_W +: TCNT_W] =
          tcnt[i*TCNT_W +: TCNT_W] + TCNT_W'(1);
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      led_q <= '0;
      tcnt  <= '0;
    end else begin
      led_q <= led_s;
      if (win_end) begin
        for (int i = 0; i < N_LEDS; i++)
          tcnt[i*TCNT_W +: TCNT_W] <= TCNT_W'(tgl[i]);
      end else begin
        tcnt <= tcnt_inc;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst)
      snap_toggles <= '0;
    else if (load)
      snap_toggles <= tcnt_inc;
  end
`else
  assign snap_toggles = '0;
`endif

  always_ff @(posedge clki) begin
    if (rst) begin
      snap_valid <= 1'b0;
      snap_leds  <= '0;
      snap_seq   <= '0;
      seq        <= '0;
      overrun    <= 1'b0;
    end else begin
      if (win_end)
        seq <= seq + 16'd1;
      if (load) begin
        snap_valid <= 1'b1;
        snap_leds  <= led_s;
        snap_seq   <= seq + 16'd1;
      end else if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
      if (win_end && !load)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_sampler.sv
// tb_led_sampler: scoreboard bench for led_sampler with SAMPLE_PERIOD=16.
// Toggle expectations track LED_SAMPLER_TOGGLE_CNT_EN.
module tb_led_sampler;

  localparam int P = 16;
`ifdef LED_SAMPLER_TOGGLE_CNT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] seq;
    logic [4:0]  leds;
    logic [39:0] tog;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap_ready = 1'b0;
  logic [4:0]  led_in = '0;
  logic [4:0]  s_led = '0;
  logic        snap_valid, overrun, s_valid, s_ovr;
  logic [4:0]  snap_leds, s_leds;
  logic [39:0] snap_toggles;
  logic [9:0]  s_tog;
  logic [15:0] snap_seq, s_seq;

  snap_t      exp_q[$];
  snap_t      obs_q[$];
  logic [9:0] sat_q[$];
  logic [4:0] hist[$];
  logic [4:0] shist[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_sampler #(.N_LEDS(5), .SAMPLE_PERIOD(P), .TCNT_W(8)) dut (
    .clki(clk), .rst(rst), .led_in(led_in),
    .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_leds(snap_leds), .snap_toggles(snap_toggles),
    .snap_seq(snap_seq), .overrun(overrun)
  );

  led_sampler #(.N_LEDS(5), .SAMPLE_PERIOD(P), .TCNT_W(2)) sat (
    .clki(clk), .rst(rst), .led_in(s_led),
    .snap_valid(s_valid), .snap_ready(1'b1),
    .snap_leds(s_leds), .snap_toggles(s_tog),
    .snap_seq(s_seq), .overrun(s_ovr)
  );

  always @(negedge clk) begin
    if (!rst && snap_valid && snap_ready)
      obs_q.push_back({snap_seq, snap_leds, snap_toggles});
    if (!rst && s_valid)
      sat_q.push_back(s_tog);
  end

  // Toggles seen in cycles [P*w-1, P*w+P-1]; a toggle in a window-end
  // cycle is captured and also seeds the next window.
  function automatic int n_tgl(input logic [4:0] h[$], input int w,
                               input int i);
    int n;
    int c;
    logic [4:0] prev;
    n = 0;
    for (int t = P*w - 1; t <= P*w + P - 1; t++) begin
      c = t - 2;
      if (c >= 0 && c < h.size()) begin
        prev = (c == 0) ? 5'd0 : h[c-1];
        if (h[c][i] != prev[i]) n++;
      end
    end
    return n;
  endfunction

  function automatic snap_t mk(input int w);
    snap_t s;
    int n;
    s.seq  = 16'(w + 1);
    s.leds = hist[P*w + P - 3];
    s.tog  = '0;
    for (int i = 0; i < 5; i++) begin
      n = n_tgl(hist, w, i);
      s.tog[i*8 +: 8] = TEN ? 8'(n > 255 ? 255 : n) : 8'd0;
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    snap_ready = 1'b0;
    step();
    step();
    obs_q.delete();
    exp_q.delete();
    sat_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    led_in = 5'b11111;
    snap_ready = 1'b0;
    step();
    step();
    tests++;
    if ({snap_valid, snap_leds, snap_toggles, snap_seq, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b l=%b t=%h s=%0d o=%b want all 0",
               snap_valid, snap_leds, snap_toggles, snap_seq, overrun);
    end
  endtask

  task automatic test_static();
    snap_t e, o;
    do_reset();
    hist.delete();
    for (int c = 0; c < 49; c++) hist.push_back(5'b10110);
    for (int w = 0; w < 3; w++) exp_q.push_back(mk(w));
    snap_ready = 1'b1;
    for (int c = 0; c < 49; c++) begin
      led_in = hist[c];
      if (c == 15 || c == 17) begin
        tests++;
        if (snap_valid !== 1'b0) begin
          fails++;
          $display("FAIL static_valid_low c=%0d: got %b want 0", c, snap_valid);
        end
      end
      if (c == 16) begin
        tests++;
        if (snap_valid !== 1'b1) begin
          fails++;
          $display("FAIL static_first_valid: got %b want 1", snap_valid);
        end
      end
      step();
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL static_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL static_snap: got s=%0d l=%b t=%h want s=%0d l=%b t=%h",
                 o.seq, o.leds, o.tog, e.seq, e.leds, e.tog);
      end
    end
  endtask

  task automatic test_toggle();
    snap_t e, o;
    do_reset();
    hist.delete();
    for (int c = 0; c < 49; c++) hist.push_back(5'((c >> 1) & 1));
    for (int w = 0; w < 3; w++) exp_q.push_back(mk(w));
    snap_ready = 1'b1;
    for (int c = 0; c < 49; c++) begin
      led_in = hist[c];
      step();
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL toggle_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL toggle_snap: got s=%0d l=%b t=%h want s=%0d l=%b t=%h",
                 o.seq, o.leds, o.tog, e.seq, e.leds, e.tog);
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] got, want;
    int n;
    logic b;
    do_reset();
    shist.delete();
    for (int c = 0; c < 34; c++) begin
      b = (c < 13) ? c[0] : (c == 20 || c == 21);
      shist.push_back({3'b000, b, 1'b0});
    end
    for (int c = 0; c < 34; c++) begin
      led_in = '0;
      s_led = shist[c];
      step();
    end
    tests++;
    if (sat_q.size() != 2) begin
      fails++;
      $display("FAIL sat_count: got %0d want 2", sat_q.size());
    end
    for (int w = 0; w < 2 && sat_q.size() > 0; w++) begin
      got = sat_q.pop_front();
      want = '0;
      for (int i = 0; i < 5; i++) begin
        n = n_tgl(shist, w, i);
        want[i*2 +: 2] = TEN ? 2'(n > 3 ? 3 : n) : 2'd0;
      end
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL sat_window%0d: got %h want %h", w, got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    snap_t e, o;
    do_reset();
    hist.delete();
    for (int c = 0; c < 50; c++) hist.push_back(5'b01001);
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(2));
    for (int c = 0; c < 50; c++) begin
      led_in = hist[c];
      snap_ready = (c >= 36);
      if (c == 31) begin
        tests++;
        if (overrun !== 1'b0) begin
          fails++;
          $display("FAIL bp_overrun_early: got %b want 0", overrun);
        end
      end
      if (c == 32 || c == 36) begin
        tests++;
        if ({overrun, snap_valid, snap_seq} !== {1'b1, 1'b1, 16'd1}) begin
          fails++;
          $display("FAIL bp_hold c=%0d: got o=%b v=%b s=%0d want o=1 v=1 s=1",
                   c, overrun, snap_valid, snap_seq);
        end
      end
      step();
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL bp_snap: got s=%0d l=%b t=%h want s=%0d l=%b t=%h",
                 o.seq, o.leds, o.tog, e.seq, e.leds, e.tog);
      end
    end
  endtask

  task automatic test_coincident();
    snap_t e, o;
    do_reset();
    hist.delete();
    for (int c = 0; c < 42; c++) hist.push_back(5'b00110);
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(1));
    for (int c = 0; c < 42; c++) begin
      led_in = hist[c];
      snap_ready = (c == 31 || c >= 40);
      if (c == 32) begin
        tests++;
        if ({snap_valid, snap_seq, overrun} !== {1'b1, 16'd2, 1'b0}) begin
          fails++;
          $display("FAIL coin_reload: got v=%b s=%0d o=%b want v=1 s=2 o=0",
                   snap_valid, snap_seq, overrun);
        end
      end
      if (c == 40) begin
        tests++;
        if (overrun !== 1'b0) begin
          fails++;
          $display("FAIL coin_overrun: got %b want 0", overrun);
        end
      end
      step();
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL coin_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL coin_snap: got s=%0d l=%b t=%h want s=%0d l=%b t=%h",
                 o.seq, o.leds, o.tog, e.seq, e.leds, e.tog);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [39:0] tw;
    tw = TEN ? 40'h01_01_00_00_00 : 40'h0;
    do_reset();
    for (int c = 0; c < 44; c++) begin
      led_in = 5'b11000;
      if (c == 26) rst = 1'b0;
      if (c == 25) begin
        tests++;
        if ({snap_valid, snap_seq} !== {1'b1, 16'd1}) begin
          fails++;
          $display("FAIL rmid_pre: got v=%b s=%0d want v=1 s=1",
                   snap_valid, snap_seq);
        end
        rst = 1'b1;
      end
      if (c == 26) begin
        tests++;
        if ({snap_valid, snap_leds, snap_toggles, snap_seq, overrun} !== '0) begin
          fails++;
          $display("FAIL rmid_clear: got v=%b l=%b t=%h s=%0d o=%b want all 0",
                   snap_valid, snap_leds, snap_toggles, snap_seq, overrun);
        end
      end
      if (c == 41) begin
        tests++;
        if (snap_valid !== 1'b0) begin
          fails++;
          $display("FAIL rmid_early: got %b want 0", snap_valid);
        end
      end
      if (c == 42) begin
        tests++;
        if ({snap_valid, snap_seq, snap_leds, snap_toggles} !==
            {1'b1, 16'd1, 5'b11000, tw}) begin
          fails++;
          $display("FAIL rmid_snap: got v=%b s=%0d l=%b t=%h want v=1 s=1 l=11000 t=%h",
                   snap_valid, snap_seq, snap_leds, snap_toggles, tw);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_toggle();
    test_saturation();
    test_backpressure();
    test_coincident();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
